// File: rtl/rf_wport_pkg.sv
// rf_wport_pkg: shared register-file geometry, address type and round-robin picker
package rf_wport_pkg;
  localparam int RF_DEPTH = 16;
  localparam int RF_AW = 4;
  typedef logic [RF_AW-1:0] rf_addr_t;
  // One-hot grant over up to 8 requesters; search starts after last and wraps at n
  function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] last, input int n);
    logic [7:0] g;
    int j;
    g = '0;
    for (int k = 1; k <= 8; k++) begin
      j = int'(last) + k;
      if (j >= n) j = j - n;
      if (k <= n && g == '0 && valid[3'(j)]) g[3'(j)] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bits per register entry with 4-port lookup and population count
module rf_scoreboard
  import rf_wport_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  rf_addr_t             set_addr,
  input  logic                 clr_en,
  input  rf_addr_t             clr_addr,
  input  logic [4*RF_AW-1:0]   rd_addr,
  output logic [3:0]           rd_busy,
  output logic [RF_AW:0]       pend_cnt
);
  logic [RF_DEPTH-1:0] busy, busy_nxt;
  // Set is applied after clear: a same-entry reservation belongs to a later write
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  always_comb begin
    pend_cnt = '0;
    rd_busy = '0;
    for (int i = 0; i < RF_DEPTH; i++) pend_cnt = pend_cnt + (RF_AW+1)'(busy[i]);
    for (int k = 0; k < 4; k++) rd_busy[k] = busy[rd_addr[RF_AW*k +: RF_AW]];
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: round-robin sharing of a register RAM write port, registered, with pending scoreboard
// Optional RF_WPORT_ZERO_DROP_EN: entry 0 is hard-wired, so its writes and reservations are discarded
module rf_wport_arbiter
  import rf_wport_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  rsv_valid,
  input  rf_addr_t              rsv_addr,
  input  logic [15:0]           rd_addr,
  output logic [3:0]            rd_busy,
  output logic [4:0]            pend_cnt,
  output rf_addr_t              ram_addrw,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_wea
);
  logic [2:0] last, gidx;
  logic [7:0] pick;
  logic any, wr_keep, rsv_en;
  rf_addr_t sel_addr;
  logic [WIDTH-1:0] sel_data;
  assign pick = rr_pick(8'(req_valid), last, NREQ);
  assign any = |pick;
  assign req_ready = pick[NREQ-1:0];
  always_comb begin
    gidx = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) begin
        gidx = 3'(i);
        sel_addr = req_addr[4*i +: 4];
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
  end
`ifdef RF_WPORT_ZERO_DROP_EN
  assign wr_keep = sel_addr != '0;
  assign rsv_en = rsv_valid && rsv_addr != '0;
`else
  assign wr_keep = 1'b1;
  assign rsv_en = rsv_valid;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_wea <= 1'b0;
      ram_addrw <= '0;
      ram_din <= '0;
      last <= 3'(NREQ-1);
    end else begin
      ram_wea <= any && wr_keep;
      if (any) begin
        ram_addrw <= sel_addr;
        ram_din <= sel_data;
        last <= gidx;
      end
    end
  rf_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (rsv_en),
    .set_addr (rsv_addr),
    .clr_en   (ram_wea),
    .clr_addr (ram_addrw),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .pend_cnt (pend_cnt)
  );
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed stimulus, expected RAM writes queued and checked by a separate monitor
module tb_rf_wport_arbiter;
  typedef struct packed {
    logic [3:0] addr;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [15:0] req_addr = '0;
  logic [127:0] req_data = '0;
  logic rsv_valid = 1'b0;
  logic [3:0] rsv_addr = '0;
  logic [15:0] rd_addr = '0;
  logic [3:0] rd_busy;
  logic [4:0] pend_cnt;
  logic [3:0] ram_addrw;
  logic [31:0] ram_din;
  logic ram_wea;
  int checks = 0, errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  rf_wport_arbiter #(.WIDTH(32), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_busy(rd_busy), .pend_cnt(pend_cnt),
    .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_wea(ram_wea)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && ram_wea) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addrw, ram_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ram_addrw", 32'(ram_addrw), 32'(mon_e.addr));
        chk("ram_din", ram_din, mon_e.data);
      end
    end
  initial begin
    step();
    step();
    chk("reset_wea", 32'(ram_wea), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_wea", 32'(ram_wea), 0);
    chk("idle_busy", 32'(rd_busy), 0);
    chk("idle_pend", 32'(pend_cnt), 0);
    chk("idle_ready", 32'(req_ready), 0);
    // all four requesters valid: grants rotate from requester 0
    req_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_all_ready", 32'(req_ready), 32'(1 << (c % 4)));
      exp_q.push_back({4'(c % 4 + 1), 32'hA0 + 32'(c % 4)});
      step();
    end
    req_valid = 4'b0010;
    #1;
    chk("set_last1_ready", 32'(req_ready), 32'b0010);
    exp_q.push_back({4'd2, 32'hA1});
    step();
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rr_13_ready", 32'(req_ready), (c % 2 == 0) ? 32'b1000 : 32'b0010);
      exp_q.push_back((c % 2 == 0) ? {4'd4, 32'hA3} : {4'd2, 32'hA1});
      step();
    end
    req_valid = '0;
    step();
    // reserve 5 then write it: busy until the cycle after the write is in the output register
    rd_addr = {4'd7, 4'd0, 4'd9, 4'd5};
    rsv_valid = 1'b1;
    rsv_addr = 4'd5;
    #1;
    chk("c0_busy", 32'(rd_busy), 0);
    step();
    rsv_valid = 1'b0;
    #1;
    chk("c1_busy", 32'(rd_busy), 32'b0001);
    chk("c1_pend", 32'(pend_cnt), 1);
    step();
    req_addr = {4'd0, 4'd0, 4'd0, 4'd5};
    req_data = {32'h0, 32'hEE, 32'h33, 32'h55};
    req_valid = 4'b0001;
    #1;
    chk("c2_ready", 32'(req_ready), 32'b0001);
    chk("c2_busy", 32'(rd_busy), 32'b0001);
    exp_q.push_back({4'd5, 32'h55});
    step();
    req_valid = '0;
    #1;
    chk("c3_wea", 32'(ram_wea), 1);
    chk("c3_busy", 32'(rd_busy), 32'b0001);
    chk("c3_pend", 32'(pend_cnt), 1);
    step();
    chk("c4_busy", 32'(rd_busy), 0);
    chk("c4_pend", 32'(pend_cnt), 0);
    // same-cycle set and clear on entry 7
    rsv_valid = 1'b1;
    rsv_addr = 4'd7;
    step();
    rsv_valid = 1'b0;
    req_addr = {4'd0, 4'd0, 4'd0, 4'd7};
    req_data = {32'h0, 32'hEE, 32'h33, 32'h77};
    req_valid = 4'b0001;
    #1;
    chk("d_ready", 32'(req_ready), 32'b0001);
    exp_q.push_back({4'd7, 32'h77});
    step();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr = 4'd7;
    #1;
    chk("d_pend_before", 32'(pend_cnt), 1);
    step();
    rsv_valid = 1'b0;
    #1;
    chk("d_setwins_pend", 32'(pend_cnt), 1);
    chk("d_setwins_busy", 32'(rd_busy), 32'b1000);
    // clear 7 while reserving 9
    req_data = {32'h0, 32'hEE, 32'h33, 32'h78};
    req_valid = 4'b0001;
    exp_q.push_back({4'd7, 32'h78});
    step();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr = 4'd9;
    step();
    rsv_valid = 1'b0;
    #1;
    chk("d_diff_pend", 32'(pend_cnt), 1);
    chk("d_diff_busy", 32'(rd_busy), 32'b0010);
    req_addr = {4'd0, 4'd0, 4'd0, 4'd9};
    req_data = {32'h0, 32'hEE, 32'h33, 32'h99};
    req_valid = 4'b0001;
    exp_q.push_back({4'd9, 32'h99});
    step();
    req_valid = '0;
    step();
    step();
    chk("d_clean_pend", 32'(pend_cnt), 0);
    // requester 2 writes entry 0 while entry 0 is reserved
    req_addr = {4'd0, 4'd0, 4'd0, 4'd0};
    req_data = {32'h0, 32'hEE, 32'h33, 32'h99};
    req_valid = 4'b0100;
    rsv_valid = 1'b1;
    rsv_addr = 4'd0;
    #1;
    chk("e_ready", 32'(req_ready), 32'b0100);
`ifndef RF_WPORT_ZERO_DROP_EN
    exp_q.push_back({4'd0, 32'hEE});
`endif
    step();
    req_valid = '0;
    rsv_valid = 1'b0;
    #1;
`ifdef RF_WPORT_ZERO_DROP_EN
    chk("e_wea", 32'(ram_wea), 0);
    chk("e_pend", 32'(pend_cnt), 0);
    chk("e_busy", 32'(rd_busy), 0);
`else
    chk("e_wea", 32'(ram_wea), 1);
    chk("e_addrw", 32'(ram_addrw), 0);
    chk("e_pend", 32'(pend_cnt), 1);
    chk("e_busy", 32'(rd_busy), 32'b0100);
`endif
    step();
    chk("e_pend_after", 32'(pend_cnt), 0);
    // asynchronous reset while a write sits in the output register
    req_addr = {4'd0, 4'd0, 4'd3, 4'd0};
    req_valid = 4'b0010;
    rsv_valid = 1'b1;
    rsv_addr = 4'd12;
    #1;
    chk("f_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    rsv_valid = 1'b0;
    #1;
    chk("f_wea_before", 32'(ram_wea), 1);
    chk("f_pend_before", 32'(pend_cnt), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("f_wea_async", 32'(ram_wea), 0);
    chk("f_pend_async", 32'(pend_cnt), 0);
    step();
    rst_n = 1'b1;
    req_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    req_valid = 4'b1111;
    #1;
    chk("f_last_reset", 32'(req_ready), 32'b0001);
    exp_q.push_back({4'd1, 32'hA0});
    step();
    req_valid = '0;
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
